// File: rtl/bitstream_byte_fetcher.sv
// Bitstream byte fetcher: buffers 32-bit slice-data words in a small FIFO and
// hands them to the arithmetic decoder one byte at a time, MSB byte first.
module bitstream_byte_fetcher #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic        flush,
  input  logic        byte_req,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        stall,
  output logic        underflow_err,
  output logic [23:0] byte_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [1:0]    idx;
  logic [1:0]    state;
  logic          ready_en;
  logic [23:0]   cnt;
  logic [31:0]   head;
  logic          push;
  logic          take;
  logic          pop;

  // occ never exceeds FIFO_DEPTH (a power of two), so its MSB alone means full
  assign word_ready    = ready_en && !occ[AW] && !flush;
  assign push          = word_valid && word_ready;
  assign byte_valid    = (occ != '0) && (state == ST_RUN);
  assign take          = byte_req && byte_valid && !flush;
  assign pop           = take && (idx == 2'd3);
  assign stall         = byte_req && !byte_valid;
  assign underflow_err = (state == ST_ERR);
  assign byte_count    = cnt;
  assign head          = mem[rd_ptr];

  always_comb begin
    byte_out = 8'h00;
    if (byte_valid) begin
      case (idx)
        2'd0:    byte_out = head[31:24];
        2'd1:    byte_out = head[23:16];
        2'd2:    byte_out = head[15:8];
        default: byte_out = head[7:0];
      endcase
    end
  end

  // Word storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      idx      <= 2'd0;
      state    <= ST_IDLE;
      ready_en <= 1'b0;
      cnt      <= 24'd0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
        idx    <= 2'd0;
        state  <= ST_IDLE;
        cnt    <= 24'd0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: occ <= occ;
        endcase
        if (take) begin
          idx <= idx + 2'd1;
          cnt <= cnt + 24'd1;
        end
        case (state)
          ST_IDLE: if (push) state <= ST_RUN;
          ST_RUN:  if (byte_req && !byte_valid) state <= ST_ERR;
          ST_ERR:  state <= ST_ERR;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bitstream_byte_fetcher.sv
// Bench for bitstream_byte_fetcher: constant vector table, hand-built corner
// sequences and random traffic against a byte-queue reference model.
module tb_bitstream_byte_fetcher;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        flush;
  logic        byte_req;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        stall;
  logic        underflow_err;
  logic [23:0] byte_count;

  bitstream_byte_fetcher #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .flush(flush), .byte_req(byte_req),
    .byte_out(byte_out), .byte_valid(byte_valid), .stall(stall),
    .underflow_err(underflow_err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: pending bytes in stream order; 0 idle, 1 run, 2 error
  logic [7:0] mq[$];
  int         m_st;
  int         m_cnt;
  bit         m_ready_en;

  typedef struct {
    logic        wv;
    logic [31:0] w;
    logic        br;
    logic        fl;
    logic        e_rdy;
    logic        e_bv;
    logic [7:0]  e_byte;
    logic        e_stall;
    logic        e_err;
    logic [23:0] e_cnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic wv, logic [31:0] w, logic br, logic fl, logic rdy,
                              logic bv, logic [7:0] b, logic st, logic er, logic [23:0] c);
    vec_t v;
    v.wv = wv; v.w = w; v.br = br; v.fl = fl; v.e_rdy = rdy; v.e_bv = bv;
    v.e_byte = b; v.e_stall = st; v.e_err = er; v.e_cnt = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_words();
    return (mq.size() + 3) / 4;
  endfunction

  function automatic bit m_bv();
    return (mq.size() > 0) && (m_st == 1);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_st = 0;
    m_cnt = 0;
    m_ready_en = 0;
  endtask

  task automatic model_step();
    bit rdy;
    bit bv;
    rdy = m_ready_en && (m_words() < DEPTH);
    bv  = m_bv();
    if (flush) begin
      mq.delete();
      m_st = 0;
      m_cnt = 0;
    end else begin
      if (byte_req && bv) begin
        void'(mq.pop_front());
        m_cnt = (m_cnt + 1) % (1 << 24);
      end
      if (m_st == 1 && byte_req && !bv) m_st = 2;
      if (word_valid && rdy) begin
        for (int k = 3; k >= 0; k--) mq.push_back(word_in[8*k +: 8]);
        if (m_st == 0) m_st = 1;
      end
    end
    m_ready_en = 1;
  endtask

  task automatic check_model();
    bit bv;
    bv = m_bv();
    chk("m_word_ready", word_ready, m_ready_en && (m_words() < DEPTH) && !flush);
    chk("m_byte_valid", byte_valid, bv);
    chk("m_byte_out", byte_out, bv ? mq[0] : 8'h00);
    chk("m_stall", stall, byte_req && !bv);
    chk("m_underflow", underflow_err, m_st == 2);
    chk("m_byte_count", byte_count, m_cnt);
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic r, input logic f);
    word_valid = v; word_in = w; byte_req = r; flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic v, input logic [31:0] w, input logic r, input logic f);
    drive(v, w, r, f);
    @(negedge clk);
    check_model();
    tick();
  endtask

  int nstall;

  initial begin
    tbl[0]  = mk(1, 32'h11223344, 1, 0, 1, 0, 8'h00, 1, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 1, 1, 8'h11, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 1, 1, 8'h22, 0, 0, 1);
    tbl[3]  = mk(0, 0, 1, 0, 1, 1, 8'h33, 0, 0, 2);
    tbl[4]  = mk(0, 0, 1, 0, 1, 1, 8'h44, 0, 0, 3);
    tbl[5]  = mk(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 4);
    tbl[6]  = mk(1, 32'hA0A1A2A3, 0, 0, 1, 0, 8'h00, 0, 0, 4);
    tbl[7]  = mk(1, 32'hB0B1B2B3, 0, 0, 1, 1, 8'hA0, 0, 0, 4);
    tbl[8]  = mk(1, 32'hC0C1C2C3, 0, 0, 1, 1, 8'hA0, 0, 0, 4);
    tbl[9]  = mk(1, 32'hD0D1D2D3, 0, 0, 1, 1, 8'hA0, 0, 0, 4);
    tbl[10] = mk(1, 32'hE0E1E2E3, 0, 0, 0, 1, 8'hA0, 0, 0, 4);
    tbl[11] = mk(1, 32'hE0E1E2E3, 1, 0, 0, 1, 8'hA0, 0, 0, 4);
    tbl[12] = mk(1, 32'hE0E1E2E3, 1, 0, 0, 1, 8'hA1, 0, 0, 5);
    tbl[13] = mk(1, 32'hE0E1E2E3, 1, 0, 0, 1, 8'hA2, 0, 0, 6);
    tbl[14] = mk(1, 32'hE0E1E2E3, 1, 0, 0, 1, 8'hA3, 0, 0, 7);
    tbl[15] = mk(1, 32'hE0E1E2E3, 0, 0, 1, 1, 8'hB0, 0, 0, 8);
    tbl[16] = mk(0, 0, 0, 0, 0, 1, 8'hB0, 0, 0, 8);
    tbl[17] = mk(1, 32'h99999999, 1, 1, 0, 1, 8'hB0, 0, 0, 8);
    tbl[18] = mk(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0);

    // Reset values, with byte_req high to show stall follows it
    rst = 1'b1;
    drive(0, 0, 1, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst_word_ready", word_ready, 0);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_underflow", underflow_err, 0);
    chk("rst_stall", stall, 1);
    chk("rst_byte_count", byte_count, 0);
    #2 rst = 1'b0;
    drive(0, 0, 0, 0);
    #1 chk("post_rst_ready_low", word_ready, 0);
    tick();
    chk("post_rst_ready_high", word_ready, 1);

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].wv, tbl[i].w, tbl[i].br, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("v%0d_word_ready", i), word_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_byte_valid", i), byte_valid, tbl[i].e_bv);
      chk($sformatf("v%0d_byte_out", i), byte_out, tbl[i].e_byte);
      chk($sformatf("v%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("v%0d_underflow", i), underflow_err, tbl[i].e_err);
      chk($sformatf("v%0d_byte_count", i), byte_count, tbl[i].e_cnt);
      tick();
    end

    // Underflow: drain one word, request again, then words are buffered but held
    cyc(1, 32'h11223344, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    chk("uf_err_set", underflow_err, 1);
    cyc(1, 32'hAABBCCDD, 0, 0);
    drive(0, 0, 0, 0);
    chk("uf_valid_held", byte_valid, 0);
    chk("uf_err_sticky", underflow_err, 1);
    cyc(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    chk("uf_err_cleared", underflow_err, 0);

    // Flush collides with push and byte request while two words are queued
    cyc(1, 32'h01020304, 0, 0);
    cyc(1, 32'h05060708, 1, 0);
    cyc(1, 32'hDEADBEEF, 1, 1);
    cyc(1, 32'h55667788, 0, 0);
    drive(0, 0, 0, 0);
    chk("flush_first_byte", byte_out, 8'h55);
    chk("flush_count", byte_count, 0);

    // Full-rate streaming across pointer wrap
    nstall = 0;
    for (int i = 0; i < 80; i++) begin
      cyc(1, $urandom, 1, 0);
      if (i > 0 && stall) nstall++;
    end
    chk("fullrate_stalls", nstall, 0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 63) == 0);

    // Asynchronous reset mid-word (idx = 2)
    cyc(0, 0, 0, 1);
    cyc(1, 32'h12345678, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("pre_arst_byte", byte_out, 8'h56);
    #2 rst = 1'b1;
    #1;
    chk("arst_byte_valid", byte_valid, 0);
    chk("arst_byte_out", byte_out, 8'h00);
    chk("arst_word_ready", word_ready, 0);
    chk("arst_count", byte_count, 0);
    chk("arst_stall", stall, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    cyc(1, 32'hCAFEF00D, 0, 0);
    drive(0, 0, 0, 0);
    chk("arst_next_word_msb", byte_out, 8'hCA);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bitstream_byte_fetcher.md
BITSTREAM_BYTE_FETCHER -- requirements
Module: bitstream_byte_fetcher

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the word FIFO depth in 32-bit words; it is a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 word_in  input  32  slice-data word from memory; first bitstream byte is word_in[31:24].
REQ-005 word_valid  input  1  word_in holds a valid word.
REQ-006 word_ready  output  1  fetcher accepts word_in this cycle.
REQ-007 flush  input  1  synchronous discard of all buffered data (slice/tile start).
REQ-008 byte_req  input  1  arithmetic decoder consumes byte_out this cycle (renormalisation byte read).
REQ-009 byte_out  output  8  current head byte, fed to the decoder's bitstream input.
REQ-010 byte_valid  output  1  byte_out is valid.
REQ-011 stall  output  1  byte_req asserted while byte_valid is low.
REQ-012 underflow_err  output  1  sticky underflow indication.
REQ-013 byte_count  output  24  bytes consumed since the last reset or flush.

Function
REQ-014 Input handshake SHALL be valid/ready; a word SHALL be written when word_valid && word_ready at a rising edge.
REQ-015 word_ready SHALL be high iff the FIFO holds fewer than FIFO_DEPTH words and flush is low (registered occupancy, no combinational path from byte_req).
REQ-016 Unpacker SHALL keep a 2-bit byte index idx into the head word; byte_out = head[31-8*idx -: 8] (MSB byte first).
REQ-017 byte_valid SHALL be high iff FIFO is non-empty and FSM is in RUN.
REQ-018 On byte_req && byte_valid: idx increments; when idx is 3, head word SHALL pop and idx returns to 0.
REQ-019 Latency: a word accepted at edge N SHALL be visible on byte_out after edge N (next cycle) if the FIFO was empty; no bypass within the same cycle.
REQ-020 Simultaneous push and pop SHALL leave occupancy unchanged; the pointers wrap modulo FIFO_DEPTH.
REQ-021 byte_count SHALL increment by 1 per consumed byte and wrap from 0xFFFFFF to 0.
REQ-022 FSM states: IDLE, RUN, ERR.
REQ-023 IDLE -> RUN on the first accepted word; RUN -> ERR on byte_req && !byte_valid; ERR -> IDLE only on flush.
REQ-024 In ERR: byte_valid SHALL be 0 and words SHALL still be accepted until the FIFO is full.
REQ-025 underflow_err SHALL equal (state == ERR).
REQ-026 stall SHALL be combinational: byte_req && !byte_valid; it is asserted in IDLE too.
REQ-027 In IDLE, byte_req SHALL assert stall but SHALL NOT enter ERR (decoder waiting for first data).
REQ-028 On flush: FIFO emptied, idx = 0, byte_count = 0, state = IDLE; word_in and byte_req in the flush cycle SHALL be ignored.
REQ-029 flush has priority over all simultaneous events.

Reset
REQ-030 While rst is high: FIFO empty, idx = 0, byte_count = 0, state = IDLE, word_ready = 0, byte_valid = 0, byte_out = 0x00, underflow_err = 0, stall = byte_req.
REQ-031 Reset assertion mid-stream SHALL discard all buffered data immediately, without waiting for clk.
REQ-032 word_ready SHALL go high on the first clk edge after rst deasserts.

Verification
REQ-033 Push 0x11223344, then byte_req for 4 cycles -> byte_out 0x11, 0x22, 0x33, 0x44; FIFO empty afterwards, byte_count = 4.
REQ-034 Push 4 words without consuming -> word_ready = 0; a 5th word is held off; one word-pop (4 bytes) -> word_ready = 1 next cycle.
REQ-035 Continuous push and byte_req at full rate -> no stall; byte sequence matches the word stream; pointer wrap is exercised over 20 words.
REQ-036 Push one word, consume 4 bytes, then byte_req with an empty FIFO -> stall = 1, underflow_err = 1 next cycle; then push 0xAABBCCDD -> byte_valid stays 0; then flush -> IDLE, underflow_err = 0.
REQ-037 Flush asserted in the same cycle as word_valid and byte_req, with 2 words buffered -> all data discarded, byte_count = 0, next word's MSB byte appears first.
REQ-038 Assert rst asynchronously mid-word (idx = 2) -> outputs take reset values before the next edge; the following word starts at byte [31:24].
